mux_pipe_reg: RTL and testbench

Parametrised successor to the single load-enable register and the fixed 3-way select. It selects one of NSRC W-bit sources and carries the selected word through a DEPTH-stage elastic pipeline with valid/ready handshakes, flush and occupancy reporting. It sits between the iteration datapath stages of the Mandelbrot core, for example between the coordinate generator and the z^2+c unit, so a stalled consumer back-pressures the source instead of losing data.

---
 rtl/mux_pipe_reg.sv | 118 +++++++++++
 tb/tb_mux_pipe_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_reg.sv
// Source-select front end feeding a DEPTH-stage elastic valid/ready pipeline.
// Provides flush, registered occupancy and a sticky out-of-range select flag.
module mux_pipe_reg #(
    parameter  int W     = 32,
    parameter  int NSRC  = 3,
    parameter  int DEPTH = 4,
    localparam int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NSRC*W-1:0]   src_flat,
    input  logic [SELW-1:0]     sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNTW-1:0]     occupancy,
    output logic                sel_err
);

    logic [DEPTH-1:0] r_valid;
    logic [W-1:0]     r_data [DEPTH];
    logic [CNTW-1:0]  r_occ;
    logic             r_sel_err;

    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_prev_valid;
    logic [W-1:0]     w_prev_data [DEPTH];
    logic [SELW:0]    w_sel_ext;
    logic             w_sel_ok;
    logic [W-1:0]     w_src_word;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_sel_ext = {1'b0, sel};
    assign w_sel_ok  = (w_sel_ext < (SELW+1)'(NSRC));

    always_comb begin
        w_src_word = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (w_sel_ext == (SELW+1)'(k)) begin
                w_src_word = src_flat[k*W +: W];
            end
        end
    end

    assign in_ready   = w_load[0] && !flush && !reset;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_valid[DEPTH-1] && out_ready;

    // A stage can load if it, or any stage downstream of it, has room this
    // cycle; the ready chain is flattened so it has no combinational feedback.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign w_load[gi] = out_ready || !(&r_valid[DEPTH-1:gi]);
            if (gi == 0) begin : g_head
                assign w_prev_valid[gi] = w_in_xfer;
                assign w_prev_data[gi]  = w_sel_ok ? w_src_word : '0;
            end else begin : g_body
                assign w_prev_valid[gi] = r_valid[gi-1];
                assign w_prev_data[gi]  = r_data[gi-1];
            end
        end
    endgenerate

    // Data only moves with a valid word; a vacated stage keeps its stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= w_prev_valid[i];
                    if (w_prev_valid[i]) begin
                        r_data[i] <= w_prev_data[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_occ <= r_occ + CNTW'(1);
                2'b01:   r_occ <= r_occ - CNTW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else if (w_in_xfer && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end
    end

    assign out_data  = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];
    assign occupancy = r_occ;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg (W=32, NSRC=3, DEPTH=4) with an in-order
// scoreboard that predicts every output word from the accepted inputs.
module tb_mux_pipe_reg;

    localparam int W     = 32;
    localparam int NSRC  = 3;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic [NSRC*W-1:0] src_flat;
    logic [1:0]        sel;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        occupancy;
    logic              sel_err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    mux_pipe_reg #(.W(W), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_flat  (src_flat),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("check %s: %h ok", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        src_flat = {s2, s1, s0};
    endtask

    // Transfers are decided by the values stable at the falling edge.
    always @(negedge clk) begin
        logic [31:0] model;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected_out", {31'b0, out_valid}, 32'd0);
            else check_eq("sb_order", out_data, exp_q.pop_front());
        end
        if (reset || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            model = (sel < 2'd3) ? src_flat[sel*W +: W] : 32'd0;
            exp_q.push_back(model);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 2'd0; set_src(32'd0, 32'd0, 32'd0);

        // Reset state and single-word latency
        tick(); tick();
        check_eq("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
        reset = 1'b0; #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_occupancy", {29'b0, occupancy}, 32'd0);
        check_eq("rst_sel_err", {31'b0, sel_err}, 32'd0);
        sel = 2'd2; set_src(32'h1111_0000, 32'h2222_0000, 32'h0000_1234);
        in_valid = 1'b1; out_ready = 1'b1; #1;
        check_eq("lat_in_ready", {31'b0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        check_eq("lat_occ_1", {29'b0, occupancy}, 32'd1);
        tick(); check_eq("lat_t1_valid", {31'b0, out_valid}, 32'd0);
        tick(); check_eq("lat_t2_valid", {31'b0, out_valid}, 32'd0);
        tick(); check_eq("lat_t3_valid", {31'b0, out_valid}, 32'd1);
        check_eq("lat_t3_data", out_data, 32'h0000_1234);
        tick(); check_eq("lat_occ_0", {29'b0, occupancy}, 32'd0);

        // Streaming 1..8 with cycling select
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i % 3);
            set_src(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002);
            src_flat[(i % 3)*W +: W] = 32'(i + 1);
            in_valid = 1'b1; #1;
            check_eq("stream_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
            if (i >= 3) begin
                check_eq("stream_occ_full", {29'b0, occupancy}, 32'd4);
                check_eq("stream_no_gap", {31'b0, out_valid}, 32'd1);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_no_gap", {31'b0, out_valid}, 32'd1);
            tick();
        end
        check_eq("stream_drained_occ", {29'b0, occupancy}, 32'd0);
        check_eq("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure and bubble collapse
        out_ready = 1'b0; sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            set_src(32'h100 + 32'(i + 1), 32'h0, 32'h0);
            in_valid = 1'b1; #1;
            check_eq("bp_accept", {31'b0, in_ready}, 32'd1);
            tick();
        end
        set_src(32'h105, 32'h0, 32'h0); #1;
        check_eq("bp_full_not_ready", {31'b0, in_ready}, 32'd0);
        check_eq("bp_occ_full", {29'b0, occupancy}, 32'd4);
        tick(); tick();
        check_eq("bp_hold_data", out_data, 32'h101);
        out_ready = 1'b1; #1;
        check_eq("bp_full_pass_ready", {31'b0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b0;
        check_eq("bp_occ_steady", {29'b0, occupancy}, 32'd4);
        check_eq("bp_next_head", out_data, 32'h102);
        set_src(32'h106, 32'h0, 32'h0); #1;
        check_eq("bp_stall_again", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("bp_occ_drained", {29'b0, occupancy}, 32'd0);

        // Out-of-range select
        sel = 2'd3; set_src(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC);
        in_valid = 1'b1; #1;
        check_eq("oor_in_ready", {31'b0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        check_eq("oor_sel_err_set", {31'b0, sel_err}, 32'd1);
        tick(); tick(); tick();
        check_eq("oor_out_valid", {31'b0, out_valid}, 32'd1);
        check_eq("oor_out_zero", out_data, 32'd0);
        sel = 2'd0; set_src(32'h0000_0055, 32'h0, 32'h0); in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("oor_sel_err_sticky", {31'b0, sel_err}, 32'd1);

        // Flush with words in flight
        out_ready = 1'b0; sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            set_src(32'h0, 32'h301 + 32'(i), 32'h0); in_valid = 1'b1;
            tick();
        end
        check_eq("flush_pre_occ", {29'b0, occupancy}, 32'd3);
        set_src(32'h0, 32'h0000_0BAD, 32'h0); flush = 1'b1; #1;
        check_eq("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_occ", {29'b0, occupancy}, 32'd0);
        check_eq("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("flush_keeps_sel_err", {31'b0, sel_err}, 32'd1);
        set_src(32'h0, 32'h0000_CAFE, 32'h0); in_valid = 1'b1; out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("flush_next_valid", {31'b0, out_valid}, 32'd1);
        check_eq("flush_next_word", out_data, 32'h0000_CAFE);
        tick();

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = (i == 2) ? 2'd3 : 2'd0;
            set_src(32'h400 + 32'(i), 32'h0, 32'h0); in_valid = 1'b1;
            tick();
        end
        check_eq("mid_full", {29'b0, occupancy}, 32'd4);
        check_eq("mid_sel_err", {31'b0, sel_err}, 32'd1);
        reset = 1'b1; flush = 1'b1; sel = 2'd0; #1;
        check_eq("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; #1;
        check_eq("mid_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid_out_data", out_data, 32'd0);
        check_eq("mid_occ", {29'b0, occupancy}, 32'd0);
        check_eq("mid_sel_err_clr", {31'b0, sel_err}, 32'd0);
        sel = 2'd1; set_src(32'h0, 32'h0000_600D, 32'h0); in_valid = 1'b1; out_ready = 1'b1; #1;
        check_eq("post_in_ready", {31'b0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        tick(); tick();
        check_eq("post_t2_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check_eq("post_t3_valid", {31'b0, out_valid}, 32'd1);
        check_eq("post_t3_data", out_data, 32'h0000_600D);
        tick();
        check_eq("post_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
